// File: rtl/mat_transpose_stream.sv
// Streaming matrix transpose: loads a NUM_ROWS x NUM_COLS frame row-major into a
// register buffer, then drains it column-major. Load and drain never overlap.
module mat_transpose_stream #(
    parameter int NUM_ROWS   = 64,
    parameter int NUM_COLS   = 96,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         frame_err
);

    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [RW-1:0] ROW_MAX = RW'(NUM_ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(NUM_COLS - 1);

    typedef enum logic {LOAD, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   wr_row_q, wr_row_d, rd_row_q, rd_row_d;
    logic [CW-1:0]   wr_col_q, wr_col_d, rd_col_q, rd_col_d;
    logic            frame_err_q, frame_err_d;
    logic            in_fire, out_fire, wr_at_end, rd_at_end;

    logic signed [DATA_WIDTH-1:0] mem_q [NUM_ROWS][NUM_COLS];

    always_comb begin
        in_ready  = (state_q == LOAD);
        out_valid = (state_q == DRAIN);
        busy      = out_valid;
        in_fire   = in_ready & in_valid;
        out_fire  = out_valid & out_ready;
        wr_at_end = (wr_row_q == ROW_MAX) && (wr_col_q == COL_MAX);
        rd_at_end = (rd_row_q == ROW_MAX) && (rd_col_q == COL_MAX);
        out_last  = out_valid & rd_at_end;
        out_data  = mem_q[rd_row_q][rd_col_q];
        frame_err = frame_err_q;
    end

    always_comb begin
        state_d     = state_q;
        wr_row_d    = wr_row_q;
        wr_col_d    = wr_col_q;
        rd_row_d    = rd_row_q;
        rd_col_d    = rd_col_q;
        frame_err_d = frame_err_q;

        // Frame placement is purely positional; in_last only feeds the error flag.
        if (in_fire) begin
            if (in_last != wr_at_end) frame_err_d = 1'b1;
            if (wr_at_end) begin
                wr_row_d = '0;
                wr_col_d = '0;
                state_d  = DRAIN;
            end else if (wr_col_q == COL_MAX) begin
                wr_col_d = '0;
                wr_row_d = wr_row_q + RW'(1);
            end else begin
                wr_col_d = wr_col_q + CW'(1);
            end
        end

        if (out_fire) begin
            if (rd_at_end) begin
                rd_row_d = '0;
                rd_col_d = '0;
                state_d  = LOAD;
            end else if (rd_row_q == ROW_MAX) begin
                rd_row_d = '0;
                rd_col_d = rd_col_q + CW'(1);
            end else begin
                rd_row_d = rd_row_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_row_q    <= wr_row_d;
            wr_col_q    <= wr_col_d;
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Buffer contents survive reset; they are only observable once refilled.
    always_ff @(posedge clk) begin
        if (in_fire) mem_q[wr_row_q][wr_col_q] <= in_data;
    end

endmodule

// File: tb/tb_mat_transpose_stream.sv
// Bench for mat_transpose_stream (2x3): directed scenarios plus random frames,
// checked against a transpose model built from the row-major input list.
module tb_mat_transpose_stream;

    localparam int NR = 2;
    localparam int NC = 3;
    localparam int N  = NR * NC;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] in_data;
    logic               in_valid, in_last, in_ready;
    logic signed [15:0] out_data;
    logic               out_valid, out_last, out_ready, busy, frame_err;

    mat_transpose_stream #(.NUM_ROWS(NR), .NUM_COLS(NC), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic signed [15:0] tx_q[$];
    logic signed [15:0] exp_q[$];
    logic signed [15:0] got_d[$];
    logic               got_l[$];
    int hold_viol, overlap_viol, busy_viol;

    // Transposed order of the frame starting at tx_q[base]: column by column.
    function automatic void build_exp(input int base);
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                exp_q.push_back(tx_q[base + r * NC + c]);
    endfunction

    function automatic void clear_mon();
        got_d.delete(); got_l.delete(); exp_q.delete();
        hold_viol = 0; overlap_viol = 0; busy_viol = 0;
    endfunction

    task automatic set_tx6(input int a, input int b, input int c, input int d, input int e, input int f);
        tx_q.delete();
        tx_q.push_back(16'(a)); tx_q.push_back(16'(b)); tx_q.push_back(16'(c));
        tx_q.push_back(16'(d)); tx_q.push_back(16'(e)); tx_q.push_back(16'(f));
    endtask

    task automatic push_elem(input logic signed [15:0] d, input logic l);
        logic ok;
        int   n;
        ok = 1'b0; n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!ok && n < 100) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL push_timeout: in_ready never high for data %0d", d);
        end
    endtask

    // Sends every element of tx_q; in_last is set where (index mod N) == last_at.
    task automatic send_frame(input int gap_max, input int last_at);
        for (int i = 0; i < tx_q.size(); i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            push_elem(tx_q[i], (i % N) == last_at);
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random.
    task automatic drain(input int n, input int mode, input int budget);
        int k, cyc;
        logic stalled, pl;
        logic signed [15:0] pd;
        k = 0; cyc = 0; stalled = 1'b0; pl = 1'b0; pd = '0;
        while (k < n && cyc < budget) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (stalled && (out_data !== pd || out_last !== pl)) hold_viol++;
            if (in_ready === out_valid) overlap_viol++;
            if (busy !== out_valid) busy_viol++;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data); got_l.push_back(out_last); k++;
            end
            stalled = out_valid && !out_ready; pd = out_data; pl = out_last;
            @(posedge clk); #1; cyc++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        clear_mon(); set_tx6(1, 2, 3, 4, 5, 6); build_exp(0);
        send_frame(0, N - 1);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency: out_valid %b want 1", out_valid); end
        @(posedge clk); #1;
        drain(N, 0, 100);
        n_vec++; if (got_d.size() != N) begin n_err++; $display("FAIL basic_count: got %0d want %0d", got_d.size(), N); end
        for (int i = 0; i < got_d.size() && i < N; i++) begin
            n_vec++; if (got_d[i] !== exp_q[i]) begin n_err++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, got_d[i], exp_q[i]); end
            n_vec++; if (got_l[i] !== (i == N - 1)) begin n_err++; $display("FAIL basic_last[%0d]: got %b want %b", i, got_l[i], i == N - 1); end
        end
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_back: got %b want 1", in_ready); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL basic_frame_err: got %b want 0", frame_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        clear_mon(); set_tx6(1, 2, 3, 4, 5, 6); build_exp(0);
        send_frame(0, N - 1);
        drain(N, 1, 200);
        n_vec++; if (hold_viol != 0) begin n_err++; $display("FAIL stall_hold: %0d changes while stalled, want 0", hold_viol); end
        n_vec++; if (got_d.size() != N) begin n_err++; $display("FAIL stall_count: got %0d want %0d", got_d.size(), N); end
        for (int i = 0; i < got_d.size() && i < N; i++) begin
            n_vec++; if (got_d[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_data[%0d]: got %0d want %0d", i, got_d[i], exp_q[i]); end
        end
    endtask

    task automatic test_signed_gaps();
        clear_mon(); set_tx6(-1, -32768, 32767, 0, 5, -7); build_exp(0);
        send_frame(2, N - 1);
        drain(N, 0, 100);
        n_vec++; if (got_d.size() != N) begin n_err++; $display("FAIL signed_count: got %0d want %0d", got_d.size(), N); end
        for (int i = 0; i < got_d.size() && i < N; i++) begin
            n_vec++; if (got_d[i] !== exp_q[i]) begin n_err++; $display("FAIL signed_data[%0d]: got %0d want %0d", i, got_d[i], exp_q[i]); end
        end
    endtask

    task automatic test_frame_err();
        clear_mon(); set_tx6(21, 22, 23, 24, 25, 26); build_exp(0);
        for (int i = 0; i < N; i++) begin
            push_elem(tx_q[i], (i == 2) || (i == N - 1));
            @(negedge clk);
            n_vec++; if (frame_err !== (i >= 2)) begin n_err++; $display("FAIL ferr_flag[%0d]: got %b want %b", i, frame_err, i >= 2); end
            if (i < N - 1) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        drain(N, 0, 100);
        n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_sticky: got %b want 1", frame_err); end
        n_vec++; if (got_d.size() != N) begin n_err++; $display("FAIL ferr_count: got %0d want %0d", got_d.size(), N); end
        for (int i = 0; i < got_d.size() && i < N; i++) begin
            n_vec++; if (got_d[i] !== exp_q[i]) begin n_err++; $display("FAIL ferr_data[%0d]: got %0d want %0d", i, got_d[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_drain();
        clear_mon(); set_tx6(1, 2, 3, 4, 5, 6);
        send_frame(0, N - 1);
        drain(4, 0, 100);
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_frame_err: got %b want 0", frame_err); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
        clear_mon(); set_tx6(10, 11, 12, 13, 14, 15); build_exp(0);
        send_frame(0, N - 1);
        drain(N, 0, 100);
        n_vec++; if (got_d.size() != N) begin n_err++; $display("FAIL mid_rst_count: got %0d want %0d", got_d.size(), N); end
        for (int i = 0; i < got_d.size() && i < N; i++) begin
            n_vec++; if (got_d[i] !== exp_q[i]) begin n_err++; $display("FAIL mid_rst_data[%0d]: got %0d want %0d", i, got_d[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        tx_q.delete();
        for (int i = 0; i < 2 * N; i++) tx_q.push_back(16'(100 + i));
        build_exp(0); build_exp(N);
        fork
            send_frame(0, N - 1);
            drain(2 * N, 0, 200);
        join
        n_vec++; if (overlap_viol != 0) begin n_err++; $display("FAIL b2b_ready_overlap: %0d cycles, want 0", overlap_viol); end
        n_vec++; if (busy_viol != 0) begin n_err++; $display("FAIL b2b_busy: %0d cycles busy!=drain, want 0", busy_viol); end
        n_vec++; if (got_d.size() != 2 * N) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", got_d.size(), 2 * N); end
        for (int i = 0; i < got_d.size() && i < 2 * N; i++) begin
            n_vec++; if (got_d[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_data[%0d]: got %0d want %0d", i, got_d[i], exp_q[i]); end
            n_vec++; if (got_l[i] !== ((i % N) == N - 1)) begin n_err++; $display("FAIL b2b_last[%0d]: got %b want %b", i, got_l[i], (i % N) == N - 1); end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            clear_mon();
            tx_q.delete();
            for (int i = 0; i < N; i++) tx_q.push_back(16'($urandom));
            build_exp(0);
            fork
                send_frame(3, N - 1);
                drain(N, 2, 400);
            join
            n_vec++; if (hold_viol != 0) begin n_err++; $display("FAIL rand_hold[%0d]: %0d changes, want 0", f, hold_viol); end
            n_vec++; if (got_d.size() != N) begin n_err++; $display("FAIL rand_count[%0d]: got %0d want %0d", f, got_d.size(), N); end
            for (int i = 0; i < got_d.size() && i < N; i++) begin
                n_vec++; if (got_d[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_data[%0d][%0d]: got %0d want %0d", f, i, got_d[i], exp_q[i]); end
            end
        end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rand_frame_err: got %b want 0", frame_err); end
    endtask

    task automatic test_missing_last();
        clear_mon(); set_tx6(7, 8, 9, 10, 11, 12); build_exp(0);
        send_frame(0, -1);
        drain(N, 0, 100);
        n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL nolast_frame_err: got %b want 1", frame_err); end
        n_vec++; if (got_d.size() != N) begin n_err++; $display("FAIL nolast_count: got %0d want %0d", got_d.size(), N); end
        for (int i = 0; i < got_d.size() && i < N; i++) begin
            n_vec++; if (got_d[i] !== exp_q[i]) begin n_err++; $display("FAIL nolast_data[%0d]: got %0d want %0d", i, got_d[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_signed_gaps();
        test_frame_err();
        test_reset_mid_drain();
        test_back_to_back();
        test_random();
        test_missing_last();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
